// File: rtl/draw_scheduler.sv
// Sequences draw sources 0..SOURCE_COUNT-1 onto a shared bus and forwards their opaque pixels to the framebuffer.
// Latency: grant outputs are registered from the next state; framebuffer write appears one cycle after the bus pixel.
// Backpressure: none on the framebuffer; a source holds its grant while write_active=1, bounded by a per-source cycle budget.
module draw_scheduler #(
  parameter int SOURCE_COUNT      = 4,
  parameter int SOURCE_SEL_ADDRW  = 3,
  parameter int SEL_W             = SOURCE_SEL_ADDRW,
  parameter int TIMEOUT_CYCLES    = 4096,
  parameter int COLOR_DEPTH       = 8,
  parameter int DRAW_WIDTH_ADDRW  = 10,
  parameter int DRAW_HEIGHT_ADDRW = 9
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start,
  input  logic [SOURCE_COUNT-1:0]      source_enable,
  output logic [SEL_W-1:0]             write_source_sel,
  output logic                         write_awaited,
  input  logic                         write_active,
  input  logic                         write_transparent,
  input  logic [COLOR_DEPTH-1:0]       write_color_data,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic                         fb_we,
  output logic [DRAW_WIDTH_ADDRW-1:0]  fb_x,
  output logic [DRAW_HEIGHT_ADDRW-1:0] fb_y,
  output logic [COLOR_DEPTH-1:0]       fb_data,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         timeout_err,
  output logic                         frame_overrun
);

  localparam int IDX_W = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SEL_W-1:0] IDLE_SEL  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SOURCE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_AWAIT  = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic                         awaited_q, awaited_d;
  logic                         fb_we_q, fb_we_d;
  logic [DRAW_WIDTH_ADDRW-1:0]  fb_x_q, fb_x_d;
  logic [DRAW_HEIGHT_ADDRW-1:0] fb_y_q, fb_y_d;
  logic [COLOR_DEPTH-1:0]       fb_data_q, fb_data_d;
  logic                         done_q, done_d;
  logic                         busy_q, busy_d;
  logic                         terr_q, terr_d;
  logic                         ovr_q, ovr_d;

  logic bus_en, bus_act, bus_opaque, budget_hit;

  // Next-state, budget, pixel-forwarding and status logic; bus inputs only count while a source is granted.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fb_we_d   = 1'b0;
    fb_x_d    = fb_x_q;
    fb_y_d    = fb_y_q;
    fb_data_d = fb_data_q;
    terr_d    = terr_q;
    ovr_d     = ovr_q;

    bus_en     = (state_q == S_AWAIT) || (state_q == S_DRAW);
    bus_act    = bus_en && (write_active == 1'b1);
    bus_opaque = bus_act && (write_transparent == 1'b0);
    // Fires on the TIMEOUT_CYCLES-th granted cycle, so the grant never outlives the budget.
    budget_hit = bus_en && ((cnt_q + CNT_W'(1)) == CNT_LIMIT);

    if (bus_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The activating AWAIT cycle and the budget-expiry cycle still carry a valid pixel.
    if (bus_opaque) begin
      fb_we_d   = 1'b1;
      fb_x_d    = write_x_addr;
      fb_y_d    = write_y_addr;
      fb_data_d = write_color_data;
    end

    // A frame request is only honoured from IDLE; anything else is dropped and flagged.
    if (frame_start && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        cnt_d   = '0;
        state_d = source_enable[idx_q] ? S_AWAIT : S_NEXT;
      end
      S_AWAIT: begin
        if (budget_hit) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else if (bus_act) begin
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (budget_hit) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end else if (!bus_act) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SELECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies track the state exactly.
    sel_d     = ((state_d == S_IDLE) || (state_d == S_DONE)) ? IDLE_SEL : SEL_W'(idx_d);
    awaited_d = (state_d == S_AWAIT) || (state_d == S_DRAW);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State and registered outputs; reset drops the grant immediately and clears the sticky flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= IDLE_SEL;
      awaited_q <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_x_q    <= '0;
      fb_y_q    <= '0;
      fb_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      awaited_q <= awaited_d;
      fb_we_q   <= fb_we_d;
      fb_x_q    <= fb_x_d;
      fb_y_q    <= fb_y_d;
      fb_data_q <= fb_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign write_source_sel = sel_q;
  assign write_awaited    = awaited_q;
  assign fb_we            = fb_we_q;
  assign fb_x             = fb_x_q;
  assign fb_y             = fb_y_q;
  assign fb_data          = fb_data_q;
  assign frame_done       = done_q;
  assign busy             = busy_q;
  assign timeout_err      = terr_q;
  assign frame_overrun    = ovr_q;

endmodule
